// File: rtl/pkg_rv_decode.sv
// Shared decode constants for the CLINT: CSR modes and addresses, MMIO offsets,
// interrupt cause codes and the service FSM state type.
package pkg_rv_decode;

  typedef enum logic [1:0] {
    CSR_RW  = 2'd0,
    CSR_SET = 2'd1,
    CSR_CLR = 2'd2,
    CSR_NOP = 2'd3
  } csrmd_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } svc_state_t;

  localparam logic [11:0] CSR_MIE    = 12'h304;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MIP    = 12'h344;

  localparam logic [31:0] OFF_MTIME_LO = 32'h00;
  localparam logic [31:0] OFF_MTIME_HI = 32'h04;
  localparam logic [31:0] OFF_CMP_LO   = 32'h08;
  localparam logic [31:0] OFF_CMP_HI   = 32'h0c;
  localparam logic [31:0] OFF_MODE     = 32'h10;
  localparam logic [31:0] OFF_PEND     = 32'h14;
  localparam logic [31:0] MAP_SIZE     = 32'h18;

  localparam logic [31:0] CAUSE_TIMER    = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXT_BASE = 32'h8000_0010;

  // mcause for external line k sits at interrupt code 16+k
  function automatic logic [31:0] ext_cause(input logic [3:0] k);
    return CAUSE_EXT_BASE | {28'd0, k};
  endfunction

endpackage

// File: rtl/rv_clint_if.sv
// Core-side data bus and CSR port of the CLINT.
// Handshake: rdy is the single advance qualifier. Any write, read launch or
// CSR update takes effect only on a clock edge where rdy=1; with rdy=0 the
// block ignores d_we/d_re/csr_md and d_dr holds its last value.
interface rv_clint_if;
  import pkg_rv_decode::*;

  logic [31:0] d_adr;
  logic [31:0] d_dw;
  logic [3:0]  d_we;
  logic        d_re;
  logic [31:0] d_dr;
  logic [11:0] csr_adr;
  csrmd_t      csr_md;
  logic [31:0] csr_wd;
  logic [31:0] csr_rd;

  modport master (
    output d_adr, d_dw, d_we, d_re, csr_adr, csr_md, csr_wd,
    input  d_dr, csr_rd
  );

  modport slave (
    input  d_adr, d_dw, d_we, d_re, csr_adr, csr_md, csr_wd,
    output d_dr, csr_rd
  );

endinterface

// File: rtl/rv_irq_sync.sv
// Two-flop synchroniser for the external interrupt lines plus a third flop
// used to detect synchronised rising edges.
module rv_irq_sync #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] irq_async,
  output logic [N-1:0] level,
  output logic [N-1:0] rise
);

  logic [N-1:0] s1, s2, s3;

  // synchroniser chain; s3 remembers the previous synchronised level
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= irq_async;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/rv_clint.sv
// Core-local interruptor: 64-bit mtime/mtimecmp timer, NIRQ external lines
// (level or edge), mie/mip/mcause CSRs and a single-level in-service tracker.
module rv_clint
  import pkg_rv_decode::*;
#(
  parameter int          NIRQ = 4,
  parameter logic [31:0] BASE = 32'hffff8000,
  parameter int          TDIV = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rdy,
  rv_clint_if.slave       bus,
  input  logic [NIRQ-1:0] irq,
  output logic            irq_req,
  input  logic            irq_ack,
  input  logic            mret,
  output logic [31:0]     irq_cause,
  output svc_state_t      svc_state
);

  localparam logic [31:0] MIE_MASK =
    32'h0000_0880 | (((32'd1 << NIRQ) - 32'd1) << 16);

  logic [31:0]     off, rd_data, mie, mcause, mip, cause_nxt;
  logic            mapped, wr, tip, tick, elig, take;
  logic [63:0]     mtime, mtimecmp;
  logic [NIRQ-1:0] irq_mode, edge_pend, pend, sync_level, sync_rise;
  logic [8:0]      pre_cnt;
  svc_state_t      state, state_nxt;

  rv_irq_sync #(.N(NIRQ)) u_sync (
    .clk       (clk),
    .reset     (reset),
    .irq_async (irq),
    .level     (sync_level),
    .rise      (sync_rise)
  );

  assign off    = bus.d_adr - BASE;
  assign mapped = (off < MAP_SIZE) && (off[1:0] == 2'b00);
  assign wr     = rdy && (bus.d_we == 4'b1111) && mapped;
  assign tick   = (pre_cnt == 9'(TDIV - 1));
  assign pend   = (irq_mode & edge_pend) | (~irq_mode & sync_level);
  assign take   = rdy && irq_ack && irq_req;

  // prescaler and mtime; a word write wins over that cycle's increment
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      mtime   <= '0;
    end else begin
      pre_cnt <= tick ? 9'd0 : pre_cnt + 9'd1;
      if (wr && off == OFF_MTIME_LO)      mtime[31:0]  <= bus.d_dw;
      else if (wr && off == OFF_MTIME_HI) mtime[63:32] <= bus.d_dw;
      else if (tick)                      mtime        <= mtime + 64'd1;
    end
  end

  // compare, mode and edge-pending registers; a new edge beats a W1C
  always_ff @(posedge clk) begin
    if (reset) begin
      mtimecmp  <= '0;
      irq_mode  <= '0;
      edge_pend <= '0;
      tip       <= 1'b0;
    end else begin
      if (wr && off == OFF_CMP_LO) mtimecmp[31:0]  <= bus.d_dw;
      if (wr && off == OFF_CMP_HI) mtimecmp[63:32] <= bus.d_dw;
      if (wr && off == OFF_MODE)   irq_mode        <= bus.d_dw[NIRQ-1:0];
      edge_pend <= (edge_pend & ~((wr && off == OFF_PEND) ? bus.d_dw[NIRQ-1:0] : '0))
                   | (sync_rise & irq_mode);
      tip <= (mtime >= mtimecmp);
    end
  end

  // MMIO read mux; unmapped offsets read as zero
  always_comb begin
    rd_data = '0;
    if (mapped) begin
      case (off)
        OFF_MTIME_LO: rd_data = mtime[31:0];
        OFF_MTIME_HI: rd_data = mtime[63:32];
        OFF_CMP_LO:   rd_data = mtimecmp[31:0];
        OFF_CMP_HI:   rd_data = mtimecmp[63:32];
        OFF_MODE:     rd_data = 32'(irq_mode);
        OFF_PEND:     rd_data = 32'(pend);
        default:      rd_data = '0;
      endcase
    end
  end

  // registered read data, held while the pipeline is stalled
  always_ff @(posedge clk) begin
    if (reset)    bus.d_dr <= '0;
    else if (rdy) bus.d_dr <= bus.d_re ? rd_data : '0;
  end

  // mip view assembled from pending sources
  always_comb begin
    mip            = '0;
    mip[16 +: NIRQ] = pend;
    mip[11]        = |pend;
    mip[7]         = tip;
  end

  // combinational CSR read
  always_comb begin
    case (bus.csr_adr)
      CSR_MIE:    bus.csr_rd = mie;
      CSR_MIP:    bus.csr_rd = mip;
      CSR_MCAUSE: bus.csr_rd = mcause;
      default:    bus.csr_rd = '0;
    endcase
  end

  // mie read-modify-write and mcause capture on a taken interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      mie    <= '0;
      mcause <= '0;
    end else begin
      if (rdy && bus.csr_adr == CSR_MIE) begin
        case (bus.csr_md)
          CSR_RW:  mie <= bus.csr_wd & MIE_MASK;
          CSR_SET: mie <= mie | (bus.csr_wd & MIE_MASK);
          CSR_CLR: mie <= mie & ~bus.csr_wd;
          default: mie <= mie;
        endcase
      end
      if (take) mcause <= cause_nxt;
    end
  end

  // priority pick: timer first, then the lowest-numbered external line
  always_comb begin
    elig      = 1'b0;
    cause_nxt = '0;
    for (int k = NIRQ - 1; k >= 0; k--) begin
      if (pend[k] && mie[11] && mie[16 + k]) begin
        elig      = 1'b1;
        cause_nxt = ext_cause(4'(k));
      end
    end
    if (tip && mie[7]) begin
      elig      = 1'b1;
      cause_nxt = CAUSE_TIMER;
    end
  end

  // in-service state register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // in-service transitions; a take in IDLE wins over a simultaneous mret
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (take) state_nxt = ST_SERVICE;
      ST_SERVICE: if (rdy && mret) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign irq_req   = elig && (state == ST_IDLE);
  assign irq_cause = cause_nxt;
  assign svc_state = state;

endmodule

// File: doc/rv_clint.md
RV_CLINT -- requirements
Module: rv_clint

Interface
REQ-001 Parameter NIRQ, default 4, number of external interrupt lines (1..16).
REQ-002 Parameter BASE, default 32'hffff8000, MMIO base address.
REQ-003 Parameter TDIV, default 1, mtime prescale ratio (1..256).
REQ-004 Port clk  in  1  single clock; all state on rising edge.
REQ-005 Port reset  in  1  synchronous, active-high reset.
REQ-006 Port rdy  in  1  pipeline advance qualifier (i_rdy & d_rdy).
REQ-007 Port d_adr  in  32  data bus address.
REQ-008 Port d_dw / d_we / d_re  in  32/4/1  write data, byte write enables, read enable.
REQ-009 Port d_dr  out  32  read data, OR-combined onto the core data bus.
REQ-010 Port csr_adr / csr_md / csr_wd  in  12/2/32  CSR address, mode (RW, SET, CLR, NOP), write operand.
REQ-011 Port csr_rd  out  32  CSR read data.
REQ-012 Port irq  in  NIRQ  asynchronous external interrupt lines.
REQ-013 Port irq_req / irq_ack / mret  out/in/in  1/1/1  interrupt request, core take strobe, return strobe.
REQ-014 Port irq_cause  out  32  mcause value of the requested interrupt.

Function
REQ-015 The MMIO map SHALL be: BASE+0 mtime lo, +4 mtime hi, +8 mtimecmp lo, +C mtimecmp hi, +10 irq_mode (bit k=1 edge, 0 level), +14 irq_pend (read; write-1-to-clear edge bits).
REQ-016 An MMIO write SHALL occur only when rdy=1 and d_we=4'b1111 at a mapped address; partial writes SHALL be ignored.
REQ-017 mtime SHALL increment by 1 every TDIV clocks regardless of rdy; a write to a mtime word SHALL take precedence over the increment in that cycle and SHALL leave the other word unchanged.
REQ-018 mtime SHALL wrap from 2^64-1 to 0.
REQ-019 MMIO read data SHALL appear on d_dr one cycle after rdy & d_re, SHALL hold while rdy=0, and SHALL be 0 for unmapped addresses or when d_re=0.
REQ-020 Timer pending (mip[7]) SHALL be registered as unsigned mtime >= mtimecmp, 64-bit compare.
REQ-021 Each irq[k] SHALL pass a 2-flop synchroniser; level lines SHALL reflect the synchronised level, and edge lines SHALL set a sticky pending bit on a synchronised 0->1 transition.
REQ-022 A W1C to an edge pending bit SHALL lose to a simultaneous new edge (bit stays 1).
REQ-023 mip SHALL read {irq_pend[NIRQ-1:0] at bits 16+k, bit 11 = OR of all external pending bits, bit 7 = timer}; mip SHALL be read-only.
REQ-024 mie (0x304) SHALL support RW/SET/CLR with writable bits 7, 11, and 16..16+NIRQ-1, all others 0; mcause (0x342) SHALL be read-only; other addresses SHALL read 0.
REQ-025 CSR updates SHALL occur only when rdy=1 and csr_md!=NOP; csr_rd SHALL be combinational from csr_adr.
REQ-026 The eligible source SHALL be the highest priority of (timer, then external k from lowest index), among those with pending bit set and mie enabled; external k requires both mie[11] and mie[16+k].
REQ-027 irq_req SHALL be 1 when an eligible source exists and the in-service flag is 0; irq_cause SHALL be 32'h80000007 for timer and 32'h80000000|(16+k) for external k.
REQ-028 On irq_ack with rdy=1, the block SHALL set in-service, latch irq_cause into mcause, and deassert irq_req next cycle; irq_ack with irq_req=0 SHALL be ignored.
REQ-029 mret with rdy=1 SHALL clear in-service; simultaneous irq_ack and mret SHALL leave in-service set.
REQ-030 Taking an edge interrupt SHALL NOT clear its pending bit; software clears via W1C.

Reset
REQ-031 reset SHALL clear mtime, mtimecmp, irq_mode, irq_pend, mie, mcause, in-service, the prescaler and the synchronisers; d_dr, csr_rd data, irq_req SHALL be 0 the cycle after reset.
REQ-032 Reset asserted mid-operation SHALL override every concurrent write, ack or edge in that cycle.

Structure
REQ-033 The csrmd_t enum, the CSR address constants, MMIO offsets, and cause codes SHALL reside in pkg_rv_decode.
REQ-034 A sub-module rv_irq_sync (NIRQ-wide 2-flop synchroniser with edge detect) SHALL be instantiated once.

Verification
REQ-035 Set mtimecmp=100, mtime=90, and mie[7]=1 -> irq_req rises within 11 cycles (TDIV=1), irq_cause=32'h80000007, and irq_ack -> mcause=32'h80000007.
REQ-036 Set mtime lo=32'hffffffff and mtime hi=0, then wait one tick -> the mtime hi read returns 1 and the mtime lo read returns 0.
REQ-037 Set irq_mode=4'b0001 and pulse irq[0] for one cycle with mie[11]=1, mie[16]=1 -> pending bit 16 is sticky and irq_cause=32'h80000010; W1C 1 at +14 clears it.
REQ-038 Assert timer and irq[2] pending together -> the timer is requested first; after ack and mret, the cause becomes 32'h80000012.
REQ-039 Drive irq_ack with rdy=0 -> no state change; assert reset during an in-service interrupt -> irq_req=0 and mie=0 the next cycle.
